// File: rtl/audio_sample_mixer_if.sv
// audio_sample_mixer_if
//   Bus bundle between the drum-sample mixer, its sample ROM and the codec FIFO.
//   master : mixer side (drives ROM address and FIFO write)
//   slave  : memory / FIFO side
//   mem_addr    ROM read address
//   mem_rd_data ROM data, valid one cycle after mem_addr
//   fifo_full   codec FIFO full
//   fifo_wr_en  single-cycle write strobe
//   fifo_data   mixed sample
interface audio_sample_mixer_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
);
  logic        [ADDR_W-1:0] mem_addr;
  logic signed [DATA_W-1:0] mem_rd_data;
  logic                     fifo_full;
  logic                     fifo_wr_en;
  logic signed [DATA_W-1:0] fifo_data;

  modport master (
    output mem_addr,
    input  mem_rd_data,
    input  fifo_full,
    output fifo_wr_en,
    output fifo_data
  );

  modport slave (
    input  mem_addr,
    output mem_rd_data,
    output fifo_full,
    input  fifo_wr_en,
    input  fifo_data
  );
endinterface

// File: rtl/audio_sample_mixer.sv
// audio_sample_mixer
//   N-channel drum-sample mixer. Each frame reads one word from every active
//   channel's region of a 1-cycle-latency sample ROM, weights it by the
//   channel volume, sums, rescales (unity gain = 2^(VOL_W-1)) and writes one
//   sample to the codec FIFO.
//
//   Build option: AUDIO_MIX_SATURATE_EN
//     defined   -> result clamped to the DATA_W signed range
//     undefined -> result keeps the low DATA_W bits (two's-complement wrap)
//
// Ports
//   clk             system clock
//   reset_n         asynchronous active-low reset
//   en              frame start enable (sampled in IDLE)
//   sample_triggers per-channel 1-cycle trigger pulses
//   ch_len          per-channel sample length in words, packed SEG_ADDR_W each
//   ch_vol          per-channel volume, packed VOL_W each
//   bus             ROM / FIFO bundle (master modport)
//   ch_active       channel currently playing
//   busy            FSM not in IDLE
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for en
// LOAD  | apply pending triggers, clear accumulator, select channel 0
// ADDR  | ROM address for current channel presented
// DATA  | ROM word available; accumulate if channel active, advance
// OUT   | wait for FIFO space, then write the scaled sum
module audio_sample_mixer #(
  parameter int NUM_CH     = 4,
  parameter int DATA_W     = 16,
  parameter int SEG_ADDR_W = 16,
  parameter int VOL_W      = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         en,
  input  logic [NUM_CH-1:0]            sample_triggers,
  input  logic [NUM_CH*SEG_ADDR_W-1:0] ch_len,
  input  logic [NUM_CH*VOL_W-1:0]      ch_vol,
  audio_sample_mixer_if.master         bus,
  output logic [NUM_CH-1:0]            ch_active,
  output logic                         busy
);

  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int ADDR_W = CH_W + SEG_ADDR_W;
  localparam int ACC_W  = DATA_W + VOL_W + $clog2(NUM_CH) + 1;
  localparam int PROD_W = DATA_W + VOL_W + 1;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_ADDR = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_OUT  = 3'd4;

  logic [2:0]                state;
  logic [CH_W-1:0]           ch_idx;
  logic [SEG_ADDR_W-1:0]     pos [NUM_CH];
  logic [NUM_CH-1:0]         active;
  logic [NUM_CH-1:0]         pending;
  logic [NUM_CH-1:0]         consumed;
  logic signed [ACC_W-1:0]   acc;
  logic                      wr_en;
  logic signed [DATA_W-1:0]  data_q;

  logic [SEG_ADDR_W-1:0]     len_arr [NUM_CH];
  logic [VOL_W-1:0]          vol_arr [NUM_CH];
  logic [SEG_ADDR_W-1:0]     cur_len;
  logic signed [PROD_W-1:0]  samp_x;
  logic signed [PROD_W-1:0]  vol_x;
  logic signed [PROD_W-1:0]  prod;
  logic signed [DATA_W-1:0]  result;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
    assign len_arr[i] = ch_len[i*SEG_ADDR_W +: SEG_ADDR_W];
    assign vol_arr[i] = ch_vol[i*VOL_W +: VOL_W];
  end

  // Length and volume are looked up at use, so mid-frame edits apply to the next read.
  assign cur_len = len_arr[ch_idx];
  assign samp_x  = PROD_W'(bus.mem_rd_data);
  assign vol_x   = PROD_W'({1'b0, vol_arr[ch_idx]});
  assign prod    = samp_x * vol_x;

`ifdef AUDIO_MIX_SATURATE_EN
  localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  logic signed [ACC_W-1:0] scaled;

  always_comb begin
    scaled = acc >>> (VOL_W-1);
    if (scaled > MAX_V)      result = MAX_V[DATA_W-1:0];
    else if (scaled < MIN_V) result = MIN_V[DATA_W-1:0];
    else                     result = scaled[DATA_W-1:0];
  end
`else
  // Low DATA_W bits of (acc >>> (VOL_W-1)); the sign bits above are discarded.
  assign result = acc[VOL_W-1 +: DATA_W];
`endif

  // A trigger arriving in the LOAD cycle is ORed back in after the clear, so it waits for the next frame.
  assign consumed = (state == ST_LOAD) ? pending : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      ch_idx  <= '0;
      active  <= '0;
      pending <= '0;
      acc     <= '0;
      wr_en   <= 1'b0;
      data_q  <= '0;
      for (int i = 0; i < NUM_CH; i++) pos[i] <= '0;
    end else begin
      wr_en   <= 1'b0;
      pending <= (pending & ~consumed) | sample_triggers;
      case (state)
        ST_IDLE: begin
          if (en) state <= ST_LOAD;
        end
        ST_LOAD: begin
          // Zero-length triggers are dropped; non-zero ones (re)start from word 0.
          for (int i = 0; i < NUM_CH; i++) begin
            if (pending[i] && (len_arr[i] != '0)) begin
              active[i] <= 1'b1;
              pos[i]    <= '0;
            end
          end
          acc    <= '0;
          ch_idx <= '0;
          state  <= ST_ADDR;
        end
        ST_ADDR: begin
          state <= ST_DATA;
        end
        ST_DATA: begin
          if (active[ch_idx]) begin
            acc <= acc + ACC_W'(prod);
            if (pos[ch_idx] == cur_len - SEG_ADDR_W'(1)) begin
              active[ch_idx] <= 1'b0;
              pos[ch_idx]    <= '0;
            end else begin
              pos[ch_idx] <= pos[ch_idx] + SEG_ADDR_W'(1);
            end
          end
          if (ch_idx == CH_W'(NUM_CH-1)) begin
            state <= ST_OUT;
          end else begin
            ch_idx <= ch_idx + CH_W'(1);
            state  <= ST_ADDR;
          end
        end
        ST_OUT: begin
          if (!bus.fifo_full) begin
            wr_en  <= 1'b1;
            data_q <= result;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Inactive channels still get their ADDR/DATA slot so frame timing is fixed; the read is simply ignored.
  assign bus.mem_addr   = ADDR_W'({ch_idx, pos[ch_idx]});
  assign bus.fifo_wr_en = wr_en;
  assign bus.fifo_data  = data_q;
  assign ch_active      = active;
  assign busy           = (state != ST_IDLE);

endmodule

// File: tb/tb_audio_sample_mixer.sv
module tb_audio_sample_mixer;
  localparam int NUM_CH = 4;
  localparam int DATA_W = 16;
  localparam int SEG_W  = 4;
  localparam int VOL_W  = 4;
  localparam int ADDR_W = 2 + SEG_W;
  localparam int LAT    = 2*NUM_CH + 2;

  logic                      clk;
  logic                      reset_n;
  logic                      en;
  logic [NUM_CH-1:0]         sample_triggers;
  logic [NUM_CH*SEG_W-1:0]   ch_len;
  logic [NUM_CH*VOL_W-1:0]   ch_vol;
  logic [NUM_CH-1:0]         ch_active;
  logic                      busy;

  logic signed [DATA_W-1:0]  rom [1 << ADDR_W];
  logic signed [DATA_W-1:0]  rd_q;
  int unsigned               cyc = 0;

  int tests = 0;
  int errs  = 0;
  int q [$];

  audio_sample_mixer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  audio_sample_mixer #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .SEG_ADDR_W(SEG_W), .VOL_W(VOL_W)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .en(en),
    .sample_triggers(sample_triggers),
    .ch_len(ch_len),
    .ch_vol(ch_vol),
    .bus(bus),
    .ch_active(ch_active),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) rd_q <= rom[bus.mem_addr];
  assign bus.mem_rd_data = rd_q;

  task automatic check(input string name, input int act, input int exp_v);
    tests++;
    if (act !== exp_v) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  task automatic monitor();
    int exp_v;
    forever begin
      @(negedge clk);
      if (reset_n && bus.fifo_wr_en) begin
        if (q.size() == 0) begin
          tests++;
          errs++;
          $display("FAIL unexpected_write: got %0d, expected no write", int'(bus.fifo_data));
        end else begin
          exp_v = q.pop_front();
          check("fifo_data", int'(bus.fifo_data), exp_v);
        end
      end
    end
  endtask

  task automatic set_len(input int ch, input int v);
    ch_len[ch*SEG_W +: SEG_W] = SEG_W'(v);
  endtask

  task automatic set_vol(input int ch, input int v);
    ch_vol[ch*VOL_W +: VOL_W] = VOL_W'(v);
  endtask

  task automatic trig(input logic [NUM_CH-1:0] m);
    @(negedge clk) sample_triggers = m;
    @(negedge clk) sample_triggers = '0;
  endtask

  // One frame: pulse en, optionally pulse triggers during LOAD, expect one write after LAT cycles.
  task automatic frame(input int exp_v, input logic [NUM_CH-1:0] load_trig);
    int unsigned start;
    bit seen;
    q.push_back(exp_v);
    @(negedge clk) en = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
    start = cyc;
    if (load_trig != '0) begin
      sample_triggers = load_trig;
      @(posedge clk);
      #1 sample_triggers = '0;
    end
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (bus.fifo_wr_en) begin
        seen = 1'b1;
        check("latency", int'(cyc - start), LAT);
      end
    end
    if (!seen) check("frame_timeout", 0, 1);
  endtask

  initial begin
    int hold_ok;
    int pulses;
    reset_n         = 1'b0;
    en              = 1'b0;
    sample_triggers = '0;
    bus.fifo_full   = 1'b0;
    ch_len          = '0;
    ch_vol          = '0;
    for (int i = 0; i < (1 << ADDR_W); i++) rom[i] = '0;
    for (int i = 0; i < NUM_CH; i++) set_vol(i, 8);

    fork
      monitor();
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_wr_en", int'(bus.fifo_wr_en), 0);
    check("rst_data", int'(bus.fifo_data), 0);
    check("rst_addr", int'(bus.mem_addr), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_active", int'(ch_active), 0);
    @(negedge clk) reset_n = 1'b1;

    // Nothing playing still yields a zero write
    frame(0, '0);

    // Single channel plays its 4 words then stops
    rom[0] = 16'sd100; rom[1] = 16'sd200; rom[2] = 16'sd300; rom[3] = 16'sd400;
    set_len(0, 4);
    trig(4'b0001);
    check("pending_not_active", int'(ch_active), 0);
    frame(100, '0);
    check("ch0_active", int'(ch_active), 1);
    frame(200, '0);
    frame(300, '0);
    frame(400, '0);
    check("ch0_done", int'(ch_active), 0);
    check("idle_busy", int'(busy), 0);
    frame(0, '0);

    // Overflow: +60000 and -60000
    rom[32] = 16'sd30000; rom[33] = -16'sd30000;
    rom[48] = 16'sd30000; rom[49] = -16'sd30000;
    set_len(2, 2);
    set_len(3, 2);
    trig(4'b1100);
`ifdef AUDIO_MIX_SATURATE_EN
    frame(32767, '0);
    frame(-32768, '0);
`else
    frame(-5536, '0);
    frame(5536, '0);
`endif
    check("ovf_done", int'(ch_active), 0);

    // Volume scaling and arithmetic shift
    rom[0] = 16'sd1000; rom[1] = -16'sd3; rom[2] = 16'sd1000;
    set_len(0, 3);
    set_vol(0, 4);
    trig(4'b0001);
    frame(500, '0);
    frame(-2, '0);
    set_vol(0, 15);
    frame(1875, '0);

    // Two channels mixed, retrigger from idle and from LOAD cycle
    rom[0] = 16'sd800; rom[1] = -16'sd800; rom[2] = 16'sd1600; rom[3] = 16'sd0;
    for (int k = 0; k < 6; k++) rom[16+k] = DATA_W'(1000 + 10*k);
    set_len(0, 4);
    set_vol(0, 4);
    set_len(1, 6);
    set_vol(1, 8);
    trig(4'b0011);
    frame(1400, '0);
    frame(610, '0);
    trig(4'b0010);
    frame(1800, 4'b0010);
    frame(1000, '0);
    check("mix_active", int'(ch_active), 2);
    frame(1010, '0);

    // FIFO full holds the write
    bus.fifo_full = 1'b1;
    q.push_back(1020);
    @(negedge clk) en = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
    hold_ok = 1;
    repeat (30) begin
      @(negedge clk);
      if (bus.fifo_wr_en || bus.fifo_data != 16'sd1010 || !busy) hold_ok = 0;
    end
    check("full_hold", hold_ok, 1);
    bus.fifo_full = 1'b0;
    pulses = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.fifo_wr_en) pulses++;
    end
    check("full_release_pulses", pulses, 1);

    // Reset in the DATA cycle of channel 1 aborts the frame
    @(negedge clk) en = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("pre_rst_addr", int'(bus.mem_addr), 19);
    reset_n = 1'b0;
    #1;
    check("mid_rst_data", int'(bus.fifo_data), 0);
    check("mid_rst_active", int'(ch_active), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_addr", int'(bus.mem_addr), 0);
    check("mid_rst_wr_en", int'(bus.fifo_wr_en), 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (15) @(negedge clk);
    frame(0, '0);

    // Zero-length trigger is dropped, other channel unaffected
    set_len(3, 0);
    trig(4'b1010);
    frame(1000, '0);
    check("len0_inactive", int'(ch_active), 2);

    repeat (5) @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end
endmodule
